// File: rtl/cylon_scan_controller_if.sv
// Button/switch inputs and scan outputs of the cylon sequencer.
// master = controller side, slave = consumer (fader / board glue).
interface cylon_scan_controller_if;
    logic [3:0]  speed_sel;
    logic        btnC;
    logic        btnL;
    logic        btnR;
    logic [3:0]  pointer;
    logic [15:0] active;
    logic        direction;
    logic [1:0]  mode;
    logic        step;
    logic [29:0] linger_clks;

    modport master (
        input  speed_sel, btnC, btnL, btnR,
        output pointer, active, direction, mode, step, linger_clks
    );

    modport slave (
        output speed_sel, btnC, btnL, btnR,
        input  pointer, active, direction, mode, step, linger_clks
    );
endinterface

// File: rtl/cylon_scan_controller.sv
// Cylon sequencer: button debounce, mode FSM, step timer and
// scan pointer/direction driving the pwm_fader active/linger inputs.
module cylon_scan_controller #(
    parameter int unsigned CLOCK_CYCLES_PER_PULSE = 25_000_000,
    parameter int unsigned DEBOUNCE_CLKS          = 1_000_000
) (
    input  logic                       clk,
    input  logic                       rst,
    cylon_scan_controller_if.master    bus
);
    typedef enum logic [1:0] {
        CYLON  = 2'b00,
        LEFT   = 2'b01,
        RIGHT  = 2'b10,
        PAUSED = 2'b11
    } mode_e;

    localparam int unsigned DW =
        (DEBOUNCE_CLKS > 1) ? $clog2(DEBOUNCE_CLKS) : 1;
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CLKS - 1);
    localparam logic [29:0]   BASE    = 30'(CLOCK_CYCLES_PER_PULSE);

    // index 0 = C, 1 = L, 2 = R
    logic [2:0]    raw;
    logic [2:0]    s1_q;
    logic [2:0]    s2_q;
    logic [2:0]    lvl_q;
    logic [2:0]    press_q;
    logic [DW-1:0] cnt_q [3];

    logic [29:0] shifted;
    logic [29:0] period_d;
    logic [29:0] period_q;
    logic [29:0] linger_q;

    logic [29:0] count_q;
    logic [29:0] count_d;
    logic        step_en;
    logic        step_q;
    logic [3:0]  pointer_q;
    logic [3:0]  ptr_d;
    logic        dir_q;
    logic        dir_d;
    mode_e       mode_q;
    mode_e       mode_d;

    assign raw = {bus.btnR, bus.btnL, bus.btnC};

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= '0;
            s2_q    <= '0;
            lvl_q   <= '0;
            press_q <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q    <= raw;
            s2_q    <= s1_q;
            press_q <= '0;
            for (int i = 0; i < 3; i++) begin
                if (s2_q[i] == lvl_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == DB_LAST) begin
                    cnt_q[i]   <= '0;
                    lvl_q[i]   <= s2_q[i];
                    press_q[i] <= s2_q[i];
                end else begin
                    cnt_q[i] <= cnt_q[i] + DW'(1);
                end
            end
        end
    end

    assign shifted  = BASE >> bus.speed_sel;
    assign period_d = (shifted == '0) ? 30'd1 : shifted;

    always_ff @(posedge clk) begin
        if (rst) begin
            period_q <= BASE;
            linger_q <= BASE >> 1;
        end else begin
            period_q <= period_d;
            linger_q <= period_q >> 1;
        end
    end

    // >= so a period shrunk below the running count fires immediately
    assign step_en = (mode_q != PAUSED) &&
                     (count_q >= period_q - 30'd1);

    always_comb begin
        count_d = count_q + 30'd1;
        if (mode_q == PAUSED || step_en) begin
            count_d = '0;
        end
    end

    always_comb begin
        mode_d = mode_q;
        priority case (1'b1)
            press_q[0]: mode_d = (mode_q == CYLON) ? PAUSED : CYLON;
            press_q[2]: mode_d = RIGHT;
            press_q[1]: mode_d = LEFT;
            default:    mode_d = mode_q;
        endcase
    end

    always_comb begin
        ptr_d = pointer_q;
        dir_d = dir_q;
        if (step_en) begin
            case (mode_q)
                CYLON: begin
                    if (!dir_q) begin
                        if (pointer_q == 4'd15) begin
                            dir_d = 1'b1;
                            ptr_d = 4'd14;
                        end else begin
                            ptr_d = pointer_q + 4'd1;
                        end
                    end else begin
                        if (pointer_q == 4'd0) begin
                            dir_d = 1'b0;
                            ptr_d = 4'd1;
                        end else begin
                            ptr_d = pointer_q - 4'd1;
                        end
                    end
                end
                LEFT: begin
                    dir_d = 1'b0;
                    ptr_d = pointer_q + 4'd1;
                end
                RIGHT: begin
                    dir_d = 1'b1;
                    ptr_d = pointer_q - 4'd1;
                end
                default: begin
                    ptr_d = pointer_q;
                    dir_d = dir_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q    <= CYLON;
            count_q   <= '0;
            step_q    <= 1'b0;
            pointer_q <= 4'd0;
            dir_q     <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            count_q   <= count_d;
            step_q    <= step_en;
            pointer_q <= ptr_d;
            dir_q     <= dir_d;
        end
    end

    assign bus.pointer     = pointer_q;
    assign bus.active      = 16'b1 << pointer_q;
    assign bus.direction   = dir_q;
    assign bus.mode        = mode_q;
    assign bus.step        = step_q;
    assign bus.linger_clks = linger_q;
endmodule

// File: tb/tb_cylon_scan_controller.sv
// Directed bench for cylon_scan_controller with a cycle-level
// behavioural model checked on every falling edge.
module tb_cylon_scan_controller;
    localparam int CCP = 32;
    localparam int DB  = 4;

    logic clk = 1'b0;
    logic rst;
    int   tests_run    = 0;
    int   tests_failed = 0;

    cylon_scan_controller_if bus();

    cylon_scan_controller #(
        .CLOCK_CYCLES_PER_PULSE(CCP),
        .DEBOUNCE_CLKS         (DB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // model state
    bit m_valid = 0;
    int m_ptr, m_mode, m_period, m_linger, m_elapsed, m_nxt, m_s;
    bit m_dir, m_step, m_fire;
    int m_old_mode;
    int hist1[3], hist2[3], lvl[3], run[3], pend[3], rawv[3];

    always @(posedge clk) begin
        if (rst) begin
            m_valid   = 1;
            m_ptr     = 0;
            m_dir     = 0;
            m_mode    = 0;
            m_step    = 0;
            m_elapsed = 0;
            m_period  = CCP;
            m_linger  = CCP / 2;
            for (int b = 0; b < 3; b++) begin
                hist1[b] = 0; hist2[b] = 0;
                lvl[b] = 0; run[b] = 0; pend[b] = 0;
            end
        end else if (m_valid) begin
            m_old_mode = m_mode;
            m_fire = (m_mode != 3) && (m_elapsed + 1 >= m_period);
            if (pend[0] != 0)      m_mode = (m_mode == 0) ? 3 : 0;
            else if (pend[2] != 0) m_mode = 2;
            else if (pend[1] != 0) m_mode = 1;
            if (m_old_mode == 3 || m_fire) m_elapsed = 0;
            else m_elapsed++;
            m_step = m_fire;
            if (m_fire) begin
                if (m_old_mode == 0) begin
                    m_nxt = m_ptr + (m_dir ? -1 : 1);
                    if (m_nxt < 0 || m_nxt > 15) begin
                        m_dir = !m_dir;
                        m_nxt = m_ptr + (m_dir ? -1 : 1);
                    end
                    m_ptr = m_nxt;
                end else if (m_old_mode == 1) begin
                    m_dir = 0;
                    m_ptr = (m_ptr + 1) % 16;
                end else if (m_old_mode == 2) begin
                    m_dir = 1;
                    m_ptr = (m_ptr + 15) % 16;
                end
            end
            m_linger = m_period / 2;
            m_period = CCP >> bus.speed_sel;
            if (m_period < 1) m_period = 1;
            rawv[0] = int'(bus.btnC);
            rawv[1] = int'(bus.btnL);
            rawv[2] = int'(bus.btnR);
            for (int b = 0; b < 3; b++) begin
                pend[b] = 0;
                m_s = hist2[b];
                if (m_s != lvl[b]) begin
                    run[b]++;
                    if (run[b] == DB) begin
                        lvl[b]  = m_s;
                        run[b]  = 0;
                        pend[b] = m_s;
                    end
                end else begin
                    run[b] = 0;
                end
                hist2[b] = hist1[b];
                hist1[b] = rawv[b];
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("m_pointer", 32'(bus.pointer), 32'(m_ptr));
            check("m_active", 32'(bus.active), 32'(1) << m_ptr);
            check("m_onehot", 32'($onehot(bus.active)), 32'd1);
            check("m_direction", 32'(bus.direction), 32'(m_dir));
            check("m_mode", 32'(bus.mode), 32'(m_mode));
            check("m_step", 32'(bus.step), 32'(m_step));
            check("m_linger", 32'(bus.linger_clks), 32'(m_linger));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_step(input int budget, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (bus.step !== 1'b1 && cycles < budget);
        if (bus.step !== 1'b1) begin
            tests_run++;
            tests_failed++;
            $display("FAIL step_timeout: none in %0d cycles, wanted a step",
                     budget);
        end
    endtask

    task automatic set_btn(input int which, input logic v);
        case (which)
            0: bus.btnC = v;
            1: bus.btnL = v;
            default: bus.btnR = v;
        endcase
    endtask

    task automatic press_btn(input int which);
        set_btn(which, 1'b1);
        tick(10);
        set_btn(which, 1'b0);
        tick(10);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int hit;
        int bad;
        logic [3:0] frozen;

        rst = 1'b1;
        bus.speed_sel = 4'd0;
        bus.btnC = 1'b0;
        bus.btnL = 1'b0;
        bus.btnR = 1'b0;
        tick(3);
        check("rst_pointer", 32'(bus.pointer), 0);
        check("rst_active", 32'(bus.active), 32'h1);
        check("rst_mode", 32'(bus.mode), 0);
        check("rst_dir", 32'(bus.direction), 0);
        check("rst_step", 32'(bus.step), 0);
        check("rst_linger", 32'(bus.linger_clks), 16);

        // 1: full bounce at period 32
        rst = 1'b0;
        wait_step(40, c);
        check("first_step_lat", 32'(c), 32);
        check("first_step_ptr", 32'(bus.pointer), 1);
        for (int k = 2; k <= 31; k++) begin
            wait_step(40, c);
            check("step_period32", 32'(c), 32);
            if (k == 16) begin
                check("bounce_top_ptr", 32'(bus.pointer), 14);
                check("bounce_top_dir", 32'(bus.direction), 1);
            end
        end
        check("bounce_end_ptr", 32'(bus.pointer), 1);
        check("bounce_end_dir", 32'(bus.direction), 0);
        check("linger32", 32'(bus.linger_clks), 16);

        // 2: speed change mid-count
        tick(20);
        bus.speed_sel = 4'd2;
        wait_step(10, c);
        check("shrink_fire", 32'(c), 2);
        wait_step(20, c);
        check("step_period8", 32'(c), 8);
        check("linger8", 32'(bus.linger_clks), 4);

        // 3: btnR from pointer 0 in CYLON
        bus.speed_sel = 4'd0;
        tick(2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        bus.btnR = 1'b1;
        hit = 0;
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            if (hit == 0 && bus.mode == 2'b10) hit = i;
        end
        bus.btnR = 1'b0;
        tests_run++;
        if (hit < 5 || hit > 7) begin
            tests_failed++;
            $display("FAIL btnR_latency: got %0d, expected 5..7", hit);
        end
        wait_step(40, c);
        check("right_ptr1", 32'(bus.pointer), 15);
        wait_step(40, c);
        check("right_ptr2", 32'(bus.pointer), 14);
        wait_step(40, c);
        check("right_ptr3", 32'(bus.pointer), 13);
        check("right_dir", 32'(bus.direction), 1);

        // 4: bouncing btnL never registers
        for (int i = 0; i < 10; i++) begin
            bus.btnL = ~bus.btnL;
            tick(2);
        end
        bus.btnL = 1'b0;
        tick(20);
        check("bounce_no_press", 32'(bus.mode), 2);

        // 5: pause and resume
        press_btn(0);
        check("c_right_to_cylon", 32'(bus.mode), 0);
        press_btn(0);
        check("c_to_paused", 32'(bus.mode), 3);
        frozen = bus.pointer;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            if (bus.pointer !== frozen || bus.step !== 1'b0) bad++;
        end
        check("paused_frozen", 32'(bad), 0);
        bus.btnC = 1'b1;
        hit = 0;
        for (int i = 1; i <= 12 && hit == 0; i++) begin
            tick(1);
            if (bus.mode == 2'b00) hit = i;
        end
        check("resume_seen", 32'(hit != 0), 1);
        bus.btnC = 1'b0;
        wait_step(40, c);
        check("resume_first_step", 32'(c), 32);

        // 6: simultaneous C+R, then reset mid-run
        press_btn(1);
        check("l_to_left", 32'(bus.mode), 1);
        bus.btnC = 1'b1;
        bus.btnR = 1'b1;
        tick(10);
        bus.btnC = 1'b0;
        bus.btnR = 1'b0;
        tick(10);
        check("c_beats_r", 32'(bus.mode), 0);
        hit = 0;
        for (int i = 0; i < 2000 && hit == 0; i++) begin
            tick(1);
            if (bus.pointer == 4'd7) hit = 1;
        end
        check("reach_ptr7", 32'(hit), 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("mid_rst_ptr", 32'(bus.pointer), 0);
        check("mid_rst_active", 32'(bus.active), 32'h1);
        check("mid_rst_mode", 32'(bus.mode), 0);
        check("mid_rst_dir", 32'(bus.direction), 0);
        check("mid_rst_step", 32'(bus.step), 0);
        wait_step(40, c);
        check("post_rst_lat", 32'(c), 32);
        check("post_rst_ptr", 32'(bus.pointer), 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
